// File: rtl/rx_pkg.sv
// Shared constants and state encodings for the RX byte deinterleaver.
package rx_pkg;

  localparam int DEF_DEPTH = 2;    // codewords interleaved per block
  localparam int DEF_N     = 255;  // RS codeword length
  localparam int DEF_K     = 223;  // RS message bytes; K..N-1 are parity

  localparam int DEF_BYTES = DEF_DEPTH * DEF_N;
  localparam int IDX_W     = $clog2(DEF_BYTES);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STREAM,
    R_DRAIN
  } rstate_e;

endpackage

// File: rtl/byte_deinterleaver_if.sv
// Byte stream with block/codeword framing sideband.
interface byte_deinterleaver_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       sop;
  logic       last;
  logic       is_parity;

  modport master (output valid, data, sop, last, is_parity, input ready);
  modport slave  (input valid, data, sop, last, is_parity, output ready);
endinterface

// File: rtl/deint_bank_ram.sv
// Two-bank simple dual-port byte RAM; bank select is the address MSB.
module deint_bank_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**(AW+1)];

  // write port
  always_ff @(posedge clk)
    if (we) mem[{wbank, waddr}] <= wdata;

  // registered read; holds its value when re is low so it can act as the output stage
  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[{rbank, raddr}];
endmodule

// File: rtl/byte_deinterleaver.sv
// Ping-pong block deinterleaver: writes interleaved bytes at cw*N+pos,
// reads each completed bank linearly so codewords come out back to back.
module byte_deinterleaver
  import rx_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int N     = DEF_N,
  parameter int K     = DEF_K
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_deinterleaver_if.slave  s_axis,
  byte_deinterleaver_if.master m_axis,
  output logic                 frame_err
);
  localparam int BYTES = DEPTH * N;
  localparam int AW    = $clog2(BYTES);
  localparam int CW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW_W-1:0] CW_LAST   = CW_W'(DEPTH - 1);
  localparam logic [PW-1:0]   POS_LAST  = PW'(N - 1);
  localparam logic [AW-1:0]   ADDR_LAST = AW'(BYTES - 1);

  // ---------------- write side ----------------
  wstate_e         wstate, wstate_nxt;
  logic [CW_W-1:0] cw, cw_nxt, eff_cw;
  logic [PW-1:0]   pos, pos_nxt, eff_pos;
  logic            wr_bank, wbank_nxt;
  logic [1:0]      full_q, set_vec, clr_vec;
  logic            ready_q, err_nxt, we, wr_acc;
  logic [AW-1:0]   waddr;

  assign wr_acc       = s_axis.valid && ready_q;
  assign s_axis.ready = ready_q;

  // write FSM: sop forces k=0, framing faults discard the partial bank
  always_comb begin
    wstate_nxt = wstate;
    cw_nxt     = cw;
    pos_nxt    = pos;
    wbank_nxt  = wr_bank;
    set_vec    = '0;
    err_nxt    = 1'b0;
    we         = 1'b0;
    eff_cw     = s_axis.sop ? '0 : cw;
    eff_pos    = s_axis.sop ? '0 : pos;
    waddr      = AW'(eff_cw) * AW'(N) + AW'(eff_pos);
    if (wr_acc) begin
      if (!s_axis.sop && wstate == W_IDLE) begin
        err_nxt = 1'b1;                      // unframed byte, dropped
      end else begin
        we = 1'b1;
        if (s_axis.sop && wstate == W_FILL) err_nxt = 1'b1;
        if (eff_cw == CW_LAST && eff_pos == POS_LAST) begin
          set_vec[wr_bank] = 1'b1;           // missing last here is tolerated
          wbank_nxt        = ~wr_bank;
          wstate_nxt       = W_IDLE;
          cw_nxt           = '0;
          pos_nxt          = '0;
        end else if (s_axis.last) begin
          err_nxt    = 1'b1;                 // early last: abandon the block
          wstate_nxt = W_IDLE;
          cw_nxt     = '0;
          pos_nxt    = '0;
        end else begin
          wstate_nxt = W_FILL;
          if (eff_cw == CW_LAST) begin
            cw_nxt  = '0;
            pos_nxt = eff_pos + 1'b1;
          end else begin
            cw_nxt  = eff_cw + 1'b1;
            pos_nxt = eff_pos;
          end
        end
      end
    end
  end

  // write-side registers; ready looks at the registered full flag of the next bank,
  // so a released bank becomes writable one cycle after its flag clears
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wstate    <= W_IDLE;
      cw        <= '0;
      pos       <= '0;
      wr_bank   <= 1'b0;
      full_q    <= '0;
      ready_q   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wstate    <= wstate_nxt;
      cw        <= cw_nxt;
      pos       <= pos_nxt;
      wr_bank   <= wbank_nxt;
      full_q    <= (full_q | set_vec) & ~clr_vec;
      ready_q   <= ~full_q[wbank_nxt];
      frame_err <= err_nxt;
    end

  // ---------------- read side ----------------
  rstate_e       rstate, rstate_nxt;
  logic          rd_bank, rbank_nxt, re, out_free;
  logic [AW-1:0] raddr, raddr_nxt;
  logic [PW-1:0] rpos, rpos_nxt;
  logic          mv_q, ms_q, mp_q, ml_q;

  assign out_free = !mv_q || m_axis.ready;

  // read FSM: RAM read register is the output stage, refilled whenever it empties
  always_comb begin
    rstate_nxt = rstate;
    rbank_nxt  = rd_bank;
    raddr_nxt  = raddr;
    rpos_nxt   = rpos;
    clr_vec    = '0;
    re         = 1'b0;
    case (rstate)
      R_IDLE: if (full_q[rd_bank] && out_free) begin
        re         = 1'b1;
        rstate_nxt = R_STREAM;
      end
      R_STREAM: re = out_free;
      R_DRAIN: if (mv_q && m_axis.ready && ml_q) begin
        clr_vec[rd_bank] = 1'b1;
        rbank_nxt        = ~rd_bank;
        rstate_nxt       = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
    if (re) begin
      if (raddr == ADDR_LAST) begin
        raddr_nxt  = '0;
        rpos_nxt   = '0;
        rstate_nxt = R_DRAIN;
      end else begin
        raddr_nxt = raddr + 1'b1;
        rpos_nxt  = (rpos == POS_LAST) ? '0 : rpos + 1'b1;
      end
    end
  end

  // read-side state and output sideband, loaded together with the RAM read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rstate  <= R_IDLE;
      rd_bank <= 1'b0;
      raddr   <= '0;
      rpos    <= '0;
      mv_q    <= 1'b0;
      ms_q    <= 1'b0;
      mp_q    <= 1'b0;
      ml_q    <= 1'b0;
    end else begin
      rstate  <= rstate_nxt;
      rd_bank <= rbank_nxt;
      raddr   <= raddr_nxt;
      rpos    <= rpos_nxt;
      if (re) begin
        mv_q <= 1'b1;
        ms_q <= (rpos == '0);
        mp_q <= (rpos >= PW'(K));
        ml_q <= (raddr == ADDR_LAST);
      end else if (m_axis.ready) begin
        mv_q <= 1'b0;
        ms_q <= 1'b0;
        mp_q <= 1'b0;
        ml_q <= 1'b0;
      end
    end

  assign m_axis.valid     = mv_q;
  assign m_axis.sop       = ms_q;
  assign m_axis.is_parity = mp_q;
  assign m_axis.last      = ml_q;

  deint_bank_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wbank (wr_bank),
    .waddr (waddr),
    .wdata (s_axis.data),
    .re    (re),
    .rbank (rd_bank),
    .raddr (raddr),
    .rdata (m_axis.data)
  );
endmodule

// File: tb/tb_byte_deinterleaver.sv
// Directed bench for byte_deinterleaver with a block scoreboard.
module tb_byte_deinterleaver;
  import rx_pkg::*;
  localparam int BYTES = DEF_DEPTH * DEF_N;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       p;
    logic       l;
  } ob_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_err;

  byte_deinterleaver_if s_if ();
  byte_deinterleaver_if m_if ();

  byte_deinterleaver dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int seed, input int k);
    if (seed == 0) return 8'(k);
    return 8'(k * seed + (k >> 8) * 91 + seed);
  endfunction

  ob_t exp_q[$];

  // expected output order: out byte j is codeword j/N, position j%N
  task automatic push_block(input int seed);
    for (int j = 0; j < BYTES; j++) begin
      int cwi = j / DEF_N;
      int p   = j % DEF_N;
      ob_t e;
      e.d = pat(seed, p * DEF_DEPTH + cwi);
      e.s = (p == 0);
      e.p = (p >= DEF_K);
      e.l = (j == BYTES - 1);
      exp_q.push_back(e);
    end
  endtask

  // monitor state
  int   rmode = 0, hs = 0, ferr = 0, gaps = 0, run = 0, max_run = 0, first_v = -1;
  bit   meas = 0, in_blk = 0, held = 0, rec = 0;
  ob_t  hv;
  logic [7:0] t1_d [BYTES];
  bit         t1_s [BYTES];
  bit         t1_p [BYTES];
  bit         t1_l [BYTES];

  // drive m_ready for the next edge, then check what that edge will transfer
  always @(negedge clk) begin
    ob_t cur, e;
    case (rmode)
      0:       m_if.ready = 1'b1;
      1:       m_if.ready = (cyc % 4 == 0);
      default: m_if.ready = (hs < 120);
    endcase
    cur = {m_if.data, m_if.sop, m_if.is_parity, m_if.last};
    if (held) begin
      chk("stall_valid", 32'(m_if.valid), 1);
      chk("stall_hold", 32'(cur), 32'(hv));
    end
    held = m_if.valid && !m_if.ready;
    hv   = cur;
    if (m_if.valid && first_v < 0) first_v = cyc;
    if (rmode == 0 && in_blk && !m_if.valid) gaps++;
    if (m_if.valid && m_if.ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'(cur), 0);
      else begin
        e = exp_q.pop_front();
        chk("out_byte", 32'(cur), 32'(e));
      end
      if (rec && hs < BYTES) begin
        t1_d[hs] = m_if.data;
        t1_s[hs] = m_if.sop;
        t1_p[hs] = m_if.is_parity;
        t1_l[hs] = m_if.last;
      end
      hs++;
      in_blk = !m_if.last;
    end
    if (frame_err) ferr++;
    if (meas) begin
      run = s_if.ready ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
  end

  int last_acc = 0;

  // send n bytes starting with sop, last on index last_at (-1: none)
  task automatic send(input int seed, input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      int bud = 20000;
      s_if.valid = 1'b1;
      s_if.data  = pat(seed, k);
      s_if.sop   = (k == 0);
      s_if.last  = (k == last_at);
      while (!s_if.ready && bud > 0) begin
        @(negedge clk);
        bud--;
      end
      if (bud == 0) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      last_acc = cyc;
      @(negedge clk);
    end
    s_if.valid = 1'b0;
    s_if.sop   = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int f0, nsop, npar, nlast, bud;
    s_if.valid = 1'b0; s_if.data = '0; s_if.sop = 1'b0;
    s_if.last  = 1'b0; s_if.is_parity = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(m_if.valid), 0);
    chk("rst_s_ready", 32'(s_if.ready), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_if.ready), 1);

    // 1: single block, k mod 256
    rec = 1; hs = 0; first_v = -1;
    push_block(0);
    send(0, BYTES, BYTES - 1);
    f0 = last_acc;
    wait_drain(2000);
    rec = 0;
    chk("t1_latency", 32'(first_v - f0), 2);
    chk("t1_d0", 32'(t1_d[0]), 0);
    chk("t1_d1", 32'(t1_d[1]), 2);
    chk("t1_d254", 32'(t1_d[254]), 252);
    chk("t1_d255", 32'(t1_d[255]), 1);
    chk("t1_d256", 32'(t1_d[256]), 3);
    chk("t1_d509", 32'(t1_d[509]), 253);
    nsop = 0; npar = 0; nlast = 0;
    for (int j = 0; j < BYTES; j++) begin
      nsop += int'(t1_s[j]); npar += int'(t1_p[j]); nlast += int'(t1_l[j]);
    end
    chk("t1_sop0", 32'(t1_s[0]), 1);
    chk("t1_sop255", 32'(t1_s[255]), 1);
    chk("t1_nsop", 32'(nsop), 2);
    chk("t1_par222", 32'(t1_p[222]), 0);
    chk("t1_par223", 32'(t1_p[223]), 1);
    chk("t1_par477", 32'(t1_p[477]), 0);
    chk("t1_par478", 32'(t1_p[478]), 1);
    chk("t1_npar", 32'(npar), 64);
    chk("t1_last509", 32'(t1_l[509]), 1);
    chk("t1_nlast", 32'(nlast), 1);

    // 2: four back-to-back blocks
    gaps = 0; run = 0; max_run = 0; meas = 1;
    for (int b = 0; b < 4; b++) push_block(3 + 2 * b);
    for (int b = 0; b < 4; b++) send(3 + 2 * b, BYTES, BYTES - 1);
    wait_drain(3000);
    meas = 0;
    chk("t2_ready_low_le3", 32'(max_run <= 3), 1);
    chk("t2_gaps", 32'(gaps), 0);

    // 3: downstream accepts 1 cycle in 4
    rmode = 1; run = 0; max_run = 0; meas = 1;
    for (int b = 0; b < 3; b++) push_block(21 + 2 * b);
    for (int b = 0; b < 3; b++) send(21 + 2 * b, BYTES, BYTES - 1);
    wait_drain(20000);
    meas = 0; rmode = 0;
    chk("t3_ready_backpressure", 32'(max_run > 3), 1);

    // 4: sop again at k=100, then a good block
    f0 = ferr;
    push_block(41);
    send(39, 100, -1);
    send(41, BYTES, BYTES - 1);
    wait_drain(3000);
    chk("t4_ferr", 32'(ferr - f0), 1);

    // 5: early last at k=300, then a good block
    f0 = ferr;
    send(51, 301, 300);
    push_block(53);
    send(53, BYTES, BYTES - 1);
    wait_drain(3000);
    chk("t5_ferr", 32'(ferr - f0), 1);

    // 6: reset while output byte 120 is stalled
    rmode = 2; hs = 0;
    push_block(61);
    send(61, BYTES, BYTES - 1);
    bud = 2000;
    while (!(hs == 120 && m_if.valid) && bud > 0) begin
      @(negedge clk);
      bud--;
    end
    chk("t6_reach_120", 32'(hs), 120);
    #2 rst = 1'b1;
    held = 0; in_blk = 0;
    #1;
    chk("t6_rst_valid", 32'(m_if.valid), 0);
    chk("t6_rst_data", 32'(m_if.data), 0);
    chk("t6_rst_side", 32'({m_if.sop, m_if.is_parity, m_if.last}), 0);
    chk("t6_rst_ready", 32'(s_if.ready), 0);
    exp_q.delete();
    @(negedge clk);
    rmode = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_block(63);
    send(63, BYTES, BYTES - 1);
    wait_drain(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
